// File: rtl/frame_update_scheduler.sv
// Vertical-blanking update sequencer: grants game-state clients one at a time, in fixed priority.
// Optional per-client watchdog is built when SCHED_TIMEOUT_EN is defined.
module frame_update_scheduler #(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       hpos,
    input  logic [9:0]       vpos,
    input  logic             enable,
    input  logic [N_REQ-1:0] upd_done,
    input  logic             overrun_clr,
    output logic [N_REQ-1:0] upd_req,
    output logic             frame_tick,
    output logic             busy,
    output logic             overrun,
    output logic [N_REQ-1:0] fault,
    output logic [15:0]      frame_count
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        StIdle,
        StServe
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [N_REQ-1:0] r_upd_req;
    logic             r_frame_tick;
    logic             r_busy;
    logic             r_overrun;
    logic [15:0]      r_frame_count;

    logic w_start;
    logic w_deadline;
    logic w_last;
    logic w_done;
    logic w_expire;
    logic w_adv;

    assign w_start    = (hpos == 10'(H_ACTIVE)) && (vpos == 10'(V_ACTIVE));
    assign w_deadline = (hpos == 10'd0) && (vpos == 10'd0);
    assign w_last     = (r_idx == IDX_W'(N_REQ - 1));
    assign w_done     = (r_state == StServe) && upd_done[r_idx];
    assign w_adv      = w_done || w_expire;

`ifdef SCHED_TIMEOUT_EN
    logic [15:0]      r_wd;
    logic [N_REQ-1:0] r_fault;

    assign w_expire = (r_state == StServe) && (r_wd == 16'(TIMEOUT - 1));
    assign fault    = r_fault;
`else
    assign w_expire = 1'b0;
    assign fault    = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_idx         <= '0;
            r_upd_req     <= '0;
            r_frame_tick  <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_count <= 16'd0;
`ifdef SCHED_TIMEOUT_EN
            r_wd          <= 16'd0;
            r_fault       <= '0;
`endif
        end else begin
            r_frame_tick <= 1'b0;
            // An abort below overrides this, so a simultaneous set wins.
            if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    if (w_start && enable) begin
                        r_state       <= StServe;
                        r_idx         <= '0;
                        r_upd_req     <= N_REQ'(1);
                        r_frame_tick  <= 1'b1;
                        r_busy        <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
`ifdef SCHED_TIMEOUT_EN
                        r_wd          <= 16'd0;
                        r_fault       <= '0;
`endif
                    end
                end
                StServe: begin
                    // Completion by the last client beats a coincident deadline.
                    if (w_deadline && !(w_adv && w_last)) begin
                        r_state   <= StIdle;
                        r_idx     <= '0;
                        r_upd_req <= '0;
                        r_busy    <= 1'b0;
                        r_overrun <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
                        r_wd      <= 16'd0;
`endif
                    end else if (w_adv) begin
`ifdef SCHED_TIMEOUT_EN
                        r_wd <= 16'd0;
                        if (w_expire && !w_done) begin
                            r_fault[r_idx] <= 1'b1;
                        end
`endif
                        if (w_last) begin
                            r_state   <= StIdle;
                            r_idx     <= '0;
                            r_upd_req <= '0;
                            r_busy    <= 1'b0;
                        end else begin
                            r_idx     <= r_idx + IDX_W'(1);
                            r_upd_req <= r_upd_req << 1;
                        end
                    end else begin
`ifdef SCHED_TIMEOUT_EN
                        r_wd <= r_wd + 16'd1;
`endif
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign upd_req     = r_upd_req;
    assign frame_tick  = r_frame_tick;
    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Self-checking bench for frame_update_scheduler; grant order is checked by a scoreboard queue.
// Drives hpos/vpos directly to place start and deadline events.
module tb_frame_update_scheduler;

    localparam int N = 3;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [9:0]   hpos = 10'd700;
    logic [9:0]   vpos = 10'd490;
    logic         enable = 1'b1;
    logic [N-1:0] upd_done = '0;
    logic         overrun_clr = 1'b0;
    logic [N-1:0] upd_req;
    logic         frame_tick;
    logic         busy;
    logic         overrun;
    logic [N-1:0] fault;
    logic [15:0]  frame_count;

    int total = 0;
    int bad = 0;
    int tick_cnt = 0;
    int dly [N];
    logic [N-1:0] spur = '0;
    logic [N-1:0] exp_q [$];
    logic [N-1:0] mon_prev = '0;
    logic [15:0]  exp_fc = 16'd0;

    frame_update_scheduler #(
        .N_REQ   (N),
        .H_ACTIVE(640),
        .V_ACTIVE(480),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .enable     (enable),
        .upd_done   (upd_done),
        .overrun_clr(overrun_clr),
        .upd_req    (upd_req),
        .frame_tick (frame_tick),
        .busy       (busy),
        .overrun    (overrun),
        .fault      (fault),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Grant-order monitor: each new nonzero grant must match the next expected entry.
    always @(negedge clk) begin
        logic [N-1:0] e;
        if (frame_tick) tick_cnt++;
        if (upd_req !== mon_prev && upd_req !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL grant_order: got=%b expected=none", upd_req);
            end else begin
                e = exp_q.pop_front();
                if (upd_req !== e) begin
                    bad++;
                    $display("FAIL grant_order: got=%b expected=%b", upd_req, e);
                end
            end
        end
        mon_prev = upd_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_event();
        hpos = 10'd640;
        vpos = 10'd480;
        step();
        hpos = 10'd700;
        vpos = 10'd490;
    endtask

    task automatic push_seq(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(N'(1) << i);
    endtask

    // Client responder: runs until busy drops or the cycle budget expires.
    task automatic serve(input int max_c, input int dl_at, input int clr_at,
                         output int bcyc, output int h0, output int gaps);
        int cnt;
        logic [N-1:0] prev;
        bcyc = 0; h0 = 0; gaps = 0; cnt = 0; prev = '0;
        for (int c = 0; c < max_c; c++) begin
            if (!busy) break;
            bcyc++;
            if (upd_req == '0) gaps++;
            if (upd_req != prev) cnt = 0;
            cnt++;
            if (upd_req == 3'b001) h0++;
            upd_done = (upd_req == 3'b001) ? spur : '0;
            for (int i = 0; i < N; i++)
                if (upd_req[i] && dly[i] > 0 && cnt >= dly[i]) upd_done[i] = 1'b1;
            if (c == dl_at) begin
                hpos = 10'd0;
                vpos = 10'd0;
            end else begin
                hpos = 10'd700;
                vpos = 10'd490;
            end
            overrun_clr = (c == clr_at);
            prev = upd_req;
            step();
        end
        upd_done = '0;
        overrun_clr = 1'b0;
        hpos = 10'd700;
        vpos = 10'd490;
    endtask

    task automatic check_idle_outputs(input string tag);
        total++;
        if ({upd_req, frame_tick, busy, overrun, fault, frame_count} !== '0) begin
            bad++;
            $display("FAIL %s: req=%b tick=%b busy=%b ovr=%b fault=%b fc=%h required all zero",
                     tag, upd_req, frame_tick, busy, overrun, fault, frame_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        check_idle_outputs("reset_values");
        reset = 1'b1;
        step();
        step();
        check_idle_outputs("after_release");
    endtask

    task automatic test_normal();
        int bc, h0, gp, t0;
        dly[0] = 10; dly[1] = 10; dly[2] = 10;
        push_seq(3);
        t0 = tick_cnt;
        start_event();
        exp_fc++;
        total++;
        if (frame_tick !== 1'b1 || upd_req !== 3'b001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL normal_start: tick=%b req=%b busy=%b required 1/001/1",
                     frame_tick, upd_req, busy);
        end
        total++;
        if (frame_count !== exp_fc) begin
            bad++;
            $display("FAIL normal_count: got=%h required=%h", frame_count, exp_fc);
        end
        serve(200, -1, -1, bc, h0, gp);
        total++;
        if (bc != 30 || h0 != 10 || gp != 0) begin
            bad++;
            $display("FAIL normal_timing: busy=%0d hold0=%0d gaps=%0d required 30/10/0", bc, h0, gp);
        end
        total++;
        if (upd_req !== '0 || busy !== 1'b0 || overrun !== 1'b0 || tick_cnt - t0 != 1) begin
            bad++;
            $display("FAIL normal_end: req=%b busy=%b ovr=%b ticks=%0d required 000/0/0/1",
                     upd_req, busy, overrun, tick_cnt - t0);
        end
    endtask

    task automatic test_abort();
        int bc, h0, gp;
        dly[0] = 10; dly[1] = 0; dly[2] = 10;
        push_seq(2);
        start_event();
        exp_fc++;
        // Clear pulse coincides with the deadline: set must win.
        serve(200, 15, 15, bc, h0, gp);
        total++;
        if (upd_req !== '0 || busy !== 1'b0 || overrun !== 1'b1 || bc != 16) begin
            bad++;
            $display("FAIL abort: req=%b busy=%b ovr=%b cycles=%0d required 000/0/1/16",
                     upd_req, busy, overrun, bc);
        end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clr: got=%b required=0", overrun);
        end
    endtask

    task automatic test_watchdog();
        int bc, h0, gp;
        dly[0] = 0; dly[1] = 10; dly[2] = 10;
`ifdef SCHED_TIMEOUT_EN
        push_seq(3);
        start_event();
        exp_fc++;
        serve(200, -1, -1, bc, h0, gp);
        total++;
        if (h0 != TO || gp != 0 || fault !== 3'b001 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL watchdog: hold0=%0d gaps=%0d fault=%b ovr=%b required %0d/0/001/0",
                     h0, gp, fault, overrun, TO);
        end
        dly[0] = 3;
        push_seq(3);
        start_event();
        exp_fc++;
        total++;
        if (fault !== '0 || frame_tick !== 1'b1) begin
            bad++;
            $display("FAIL fault_clear: fault=%b tick=%b required 000/1", fault, frame_tick);
        end
        serve(200, -1, -1, bc, h0, gp);
`else
        push_seq(1);
        start_event();
        exp_fc++;
        serve(200, 30, -1, bc, h0, gp);
        total++;
        if (h0 != 31 || fault !== '0 || overrun !== 1'b1 || upd_req !== '0) begin
            bad++;
            $display("FAIL no_watchdog: hold0=%0d fault=%b ovr=%b req=%b required 31/000/1/000",
                     h0, fault, overrun, upd_req);
        end
`endif
    endtask

    task automatic test_gating();
        int bc, h0, gp, t0;
        enable = 1'b0;
        t0 = tick_cnt;
        start_event();
        step();
        total++;
        if (busy !== 1'b0 || upd_req !== '0 || tick_cnt != t0 || frame_count !== exp_fc) begin
            bad++;
            $display("FAIL gated: busy=%b req=%b ticks=%0d fc=%h required 0/000/0/%h",
                     busy, upd_req, tick_cnt - t0, frame_count, exp_fc);
        end
        enable = 1'b1;
        dly[0] = 10; dly[1] = 10; dly[2] = 10;
        spur = 3'b100;
        push_seq(3);
        start_event();
        exp_fc++;
        serve(200, -1, -1, bc, h0, gp);
        spur = '0;
        total++;
        if (bc != 30 || h0 != 10 || frame_count !== exp_fc) begin
            bad++;
            $display("FAIL spurious_done: busy=%0d hold0=%0d fc=%h required 30/10/%h",
                     bc, h0, frame_count, exp_fc);
        end
    endtask

    task automatic test_collision();
        int bc, h0, gp;
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        dly[0] = 10; dly[1] = 10; dly[2] = 10;
        push_seq(3);
        start_event();
        exp_fc++;
        serve(200, 29, -1, bc, h0, gp);
        total++;
        if (overrun !== 1'b0 || busy !== 1'b0 || bc != 30) begin
            bad++;
            $display("FAIL last_done_vs_deadline: ovr=%b busy=%b cycles=%0d required 0/0/30",
                     overrun, busy, bc);
        end
        push_seq(1);
        start_event();
        exp_fc++;
        serve(200, 9, -1, bc, h0, gp);
        total++;
        if (overrun !== 1'b1 || upd_req !== '0 || bc != 10) begin
            bad++;
            $display("FAIL mid_done_vs_deadline: ovr=%b req=%b cycles=%0d required 1/000/10",
                     overrun, upd_req, bc);
        end
    endtask

    task automatic test_reset_mid();
        int bc, h0, gp;
        dly[0] = 10; dly[1] = 10; dly[2] = 10;
        push_seq(1);
        start_event();
        serve(5, -1, -1, bc, h0, gp);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_busy: got=%b required=1", busy);
        end
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        step();
        reset = 1'b1;
        exp_fc = 16'd0;
        step();
    endtask

    task automatic test_wrap();
        int bc, h0, gp;
        force dut.r_frame_count = 16'hFFFF;
        step();
        release dut.r_frame_count;
        dly[0] = 1; dly[1] = 1; dly[2] = 1;
        push_seq(3);
        start_event();
        total++;
        if (frame_count !== 16'h0000) begin
            bad++;
            $display("FAIL count_wrap: got=%h required=0000", frame_count);
        end
        serve(50, -1, -1, bc, h0, gp);
        total++;
        if (bc != 3) begin
            bad++;
            $display("FAIL min_hold: busy=%0d required=3", bc);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_abort();
        test_watchdog();
        test_gating();
        test_collision();
        test_reset_mid();
        test_wrap();
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL grants_missing: pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
